// File: rtl/sby_pwr_seq.sv
// sby_pwr_seq: standby power-rail sequencer.
// Synchronizes the power-on request and the rail power-good, enables the
// standby regulator, waits for power-good to settle before raising DC-OK,
// and holds the rail for a fixed time after DC-OK drops on power-down.
// A loss of power-good while sequencing or on latches a fault until the
// request is withdrawn.
// Optional feature macro: SBY_PG_TIMEOUT_EN -- when defined, RAIL_ON gives
// up and faults if power-good does not arrive within 2^TMO_W-1 cycles.
module sby_pwr_seq #(
    parameter int DLY_W = 8,
    parameter int TMO_W = 12
) (
    input  logic       i_InitialSoc,
    input  logic       i_SbyReset_n,
    input  logic       i_PwrOnReq,
    input  logic       i_RailPG,
    output logic       o_SbyRailEn,
    output logic       o_DCOKSby,
    output logic       o_Fault,
    output logic [2:0] o_SeqState
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RAIL_ON  = 3'd1,
        ST_PG_DLY   = 3'd2,
        ST_ON       = 3'd3,
        ST_DCOK_OFF = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
    localparam logic [DLY_W-1:0] DLY_MAX  = {DLY_W{1'b1}};

    logic [1:0]       req_sync_q;
    logic [1:0]       pg_sync_q;
    logic             req_s;
    logic             pg_s;
    state_t           state_q;
    state_t           state_d;
    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;
    logic [DLY_W-1:0] cnt_inc;
    logic             rail_en_q;
    logic             rail_en_d;
    logic             dcok_q;
    logic             dcok_d;
    logic             fault_q;
    logic             fault_d;

`ifdef SBY_PG_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic [TMO_W-1:0] tmo_inc;

    assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : (tmo_q + TMO_ONE);

    // Power-good timeout counter, only counts while waiting in RAIL_ON.
    always_ff @(posedge i_InitialSoc or negedge i_SbyReset_n) begin
        if (!i_SbyReset_n) begin
            tmo_q <= TMO_ZERO;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign req_s   = req_sync_q[1];
    assign pg_s    = pg_sync_q[1];
    assign cnt_inc = (cnt_q == DLY_MAX) ? cnt_q : (cnt_q + DLY_ONE);

    // Two-flop synchronizers for the asynchronous request and power-good.
    always_ff @(posedge i_InitialSoc or negedge i_SbyReset_n) begin
        if (!i_SbyReset_n) begin
            req_sync_q <= 2'b00;
            pg_sync_q  <= 2'b00;
        end else begin
            req_sync_q <= {req_sync_q[0], i_PwrOnReq};
            pg_sync_q  <= {pg_sync_q[0], i_RailPG};
        end
    end

    // Next-state, counter and output decode for the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef SBY_PG_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            ST_OFF: begin
                cnt_d = DLY_ZERO;
`ifdef SBY_PG_TIMEOUT_EN
                tmo_d = TMO_ZERO;
`endif
                if (req_s) begin
                    state_d = ST_RAIL_ON;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_RAIL_ON: begin
`ifdef SBY_PG_TIMEOUT_EN
                tmo_d = tmo_inc;
`endif
                if (pg_s) begin
                    state_d = ST_PG_DLY;
                    cnt_d   = DLY_ZERO;
                end else if (!req_s) begin
                    state_d = ST_OFF;
`ifdef SBY_PG_TIMEOUT_EN
                end else if (tmo_inc == TMO_MAX) begin
                    state_d = ST_FAULT;
`endif
                end else begin
                    state_d = ST_RAIL_ON;
                end
            end
            ST_PG_DLY: begin
                // Settle completes once the held count is all-ones, so DC-OK
                // rises 2^DLY_W+1 cycles after synchronized power-good.
                if (!pg_s) begin
                    state_d = ST_FAULT;
                end else if (cnt_q == DLY_MAX) begin
                    state_d = ST_ON;
                end else begin
                    state_d = ST_PG_DLY;
                    cnt_d   = cnt_inc;
                end
            end
            ST_ON: begin
                if (!pg_s) begin
                    state_d = ST_FAULT;
                end else if (!req_s) begin
                    state_d = ST_DCOK_OFF;
                    cnt_d   = DLY_ZERO;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_DCOK_OFF: begin
                // Hold ends on the cycle the count reaches all-ones, keeping
                // the rail up for 2^DLY_W-1 cycles after DC-OK drops.
                cnt_d = cnt_inc;
                if (cnt_inc == DLY_MAX) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_DCOK_OFF;
                end
            end
            ST_FAULT: begin
                if (!req_s) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        rail_en_d = 1'b0;
        dcok_d    = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            ST_RAIL_ON, ST_PG_DLY, ST_DCOK_OFF: begin
                rail_en_d = 1'b1;
            end
            ST_ON: begin
                rail_en_d = 1'b1;
                dcok_d    = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                rail_en_d = 1'b0;
            end
        endcase
    end

    // State and settle/hold counter registers.
    always_ff @(posedge i_InitialSoc or negedge i_SbyReset_n) begin
        if (!i_SbyReset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= DLY_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered output decode so outputs switch on the transition edge.
    always_ff @(posedge i_InitialSoc or negedge i_SbyReset_n) begin
        if (!i_SbyReset_n) begin
            rail_en_q <= 1'b0;
            dcok_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            rail_en_q <= rail_en_d;
            dcok_q    <= dcok_d;
            fault_q   <= fault_d;
        end
    end

    assign o_SbyRailEn = rail_en_q;
    assign o_DCOKSby   = dcok_q;
    assign o_Fault     = fault_q;
    assign o_SeqState  = state_q;

endmodule
